// File: rtl/ball_engine.sv
// ball_engine: per-frame ball motion, wall/paddle collisions,
// scoring and serve/point/game-over sequencing.
module ball_engine #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL        = 8,
  parameter int PAD_W       = 8,
  parameter int PAD_X_L     = 16,
  parameter int PAD_X_R     = 616,
  parameter int BAT_SHORT   = 48,
  parameter int BAT_LONG    = 96,
  parameter int HOLD_FRAMES = 60,
  parameter int WIN_SCORE   = 9,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               serve,
  input  logic               en,
  input  logic               en2,
  input  logic               bat_size,
  input  logic [1:0]         mode,
  input  logic [9:0]         pad_l_y,
  input  logic [9:0]         pad_r_y,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               point,
  output logic               game_over
);

  typedef enum logic [1:0] {
    S_IDLE, S_PLAY, S_POINT, S_OVER
  } state_t;

  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [9:0]  CX = 10'((H_RES - BALL) / 2);
  localparam logic [9:0]  CY = 10'((V_RES - BALL) / 2);
  localparam logic [10:0] LF = 11'(PAD_X_L + PAD_W);
  localparam logic [10:0] RF = 11'(PAD_X_R - BALL);
  localparam logic [10:0] RE = 11'(H_RES - BALL);
  localparam logic [10:0] YM = 11'(V_RES - BALL);
  localparam logic [10:0] BL = 11'(BALL);
  localparam logic [10:0] VR = 11'(V_RES);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_FRAMES - 1);

  state_t state, nx_state;

  logic [HW-1:0]      hold, nx_hold;
  logic [9:0]         nx_x, nx_y;
  logic               nx_dx, nx_dy, nx_pt;
  logic [SCORE_W-1:0] nx_sl, nx_sr;

  logic [10:0] bx, by, s, bat, pl, pr, px, py;
  logic        pdx, pdy;
  logic        ovl_l, ovl_r, hit_l, hit_r;
  logic        lost_l, lost_r, won, hold_done;

  assign bx  = {1'b0, ball_x};
  assign by  = {1'b0, ball_y};
  assign pl  = {1'b0, pad_l_y};
  assign pr  = {1'b0, pad_r_y};
  assign s   = {8'd0, {1'b0, mode} + 3'd1};
  assign bat = bat_size ? 11'(BAT_LONG) : 11'(BAT_SHORT);

  assign ovl_l = (by + BL > pl) && (by < pl + bat);
  assign ovl_r = (by + BL > pr) && (by < pr + bat);

  // only a ball still in front of a face can be reflected by it
  assign hit_l = !dir_x && en && (bx >= LF)
              && (bx < LF + s) && ovl_l;
  assign hit_r = dir_x && en2 && (bx <= RF)
              && (bx + s > RF) && ovl_r;

  assign lost_l = !dir_x && en && !hit_l && (bx < s);
  assign lost_r = dir_x && en2 && !hit_r && (bx + s > RE);

  assign won       = (score_l == WIN) || (score_r == WIN);
  assign hold_done = (hold == HLAST);

  always_comb begin
    px  = bx;
    pdx = dir_x;
    py  = by;
    pdy = dir_y;
    if (!dir_x) begin
      if (hit_l) begin
        px  = LF;
        pdx = 1'b1;
      end else if (bx < s) begin
        px  = '0;
        pdx = 1'b1;
      end else begin
        px = bx - s;
      end
    end else begin
      if (hit_r) begin
        px  = RF;
        pdx = 1'b0;
      end else if (bx + s > RE) begin
        px  = RE;
        pdx = 1'b0;
      end else begin
        px = bx + s;
      end
    end
    if (!dir_y) begin
      if (by < s) begin
        py  = '0;
        pdy = 1'b1;
      end else begin
        py = by - s;
      end
    end else begin
      if (by + BL + s > VR) begin
        py  = YM;
        pdy = 1'b0;
      end else begin
        py = by + s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nx_state;
  end

  always_comb begin
    nx_state = state;
    unique case (state)
      S_IDLE:
        if (serve) nx_state = S_PLAY;
      S_PLAY:
        if (frame_tick && (lost_l || lost_r))
          nx_state = S_POINT;
      S_POINT:
        if (frame_tick && hold_done)
          nx_state = won ? S_OVER : S_PLAY;
      S_OVER:
        if (serve) nx_state = S_PLAY;
    endcase
  end

  always_comb begin
    nx_x    = ball_x;
    nx_y    = ball_y;
    nx_dx   = dir_x;
    nx_dy   = dir_y;
    nx_sl   = score_l;
    nx_sr   = score_r;
    nx_pt   = 1'b0;
    nx_hold = hold;
    unique case (state)
      S_IDLE: begin
        nx_x = CX;
        nx_y = CY;
      end
      S_PLAY: begin
        if (frame_tick) begin
          if (lost_l || lost_r) begin
            nx_x    = CX;
            nx_y    = CY;
            nx_dx   = lost_r;
            nx_pt   = 1'b1;
            nx_hold = '0;
            if (lost_l && score_r != WIN)
              nx_sr = score_r + 1'b1;
            if (lost_r && score_l != WIN)
              nx_sl = score_l + 1'b1;
          end else begin
            nx_x  = px[9:0];
            nx_y  = py[9:0];
            nx_dx = pdx;
            nx_dy = pdy;
          end
        end
      end
      S_POINT: begin
        nx_x = CX;
        nx_y = CY;
        if (frame_tick)
          nx_hold = hold_done ? '0 : hold + 1'b1;
      end
      S_OVER: begin
        nx_x = CX;
        nx_y = CY;
        if (serve) begin
          nx_sl = '0;
          nx_sr = '0;
          nx_dx = 1'b1;
          nx_dy = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ball_x    <= CX;
      ball_y    <= CY;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      score_l   <= '0;
      score_r   <= '0;
      point     <= 1'b0;
      game_over <= 1'b0;
      hold      <= '0;
    end else begin
      ball_x    <= nx_x;
      ball_y    <= nx_y;
      dir_x     <= nx_dx;
      dir_y     <= nx_dy;
      score_l   <= nx_sl;
      score_r   <= nx_sr;
      point     <= nx_pt;
      game_over <= (nx_state == S_OVER);
      hold      <= nx_hold;
    end
  end

endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: directed vectors and hand-built sequences
// for the ball physics and scoring engine.
module tb_ball_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       serve = 1'b0;
  logic       en = 1'b0;
  logic       en2 = 1'b0;
  logic       bat_size = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [9:0] pad_l_y = 10'd0;
  logic [9:0] pad_r_y = 10'd0;
  logic [9:0] ball_x, ball_y;
  logic       dir_x, dir_y;
  logic [3:0] score_l, score_r;
  logic       point, game_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ball_engine dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .serve(serve), .en(en), .en2(en2),
    .bat_size(bat_size), .mode(mode),
    .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .ball_x(ball_x), .ball_y(ball_y),
    .dir_x(dir_x), .dir_y(dir_y),
    .score_l(score_l), .score_r(score_r),
    .point(point), .game_over(game_over)
  );

  typedef struct {
    int         n;
    logic [1:0] mode;
    logic       en;
    logic       en2;
    logic [9:0] pl;
    int         x;
    int         y;
    int         dx;
    int         dy;
  } vec_t;

  vec_t tv[15];

  function automatic vec_t mk(int n, int m, int e, int e2,
                              int pl, int x, int y,
                              int dx, int dy);
    vec_t v;
    v.n    = n;
    v.mode = 2'(m);
    v.en   = 1'(e);
    v.en2  = 1'(e2);
    v.pl   = 10'(pl);
    v.x    = x;
    v.y    = y;
    v.dx   = dx;
    v.dy   = dy;
    return v;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm,
                         input int x, input int y,
                         input int dx, input int dy,
                         input int sl, input int sr,
                         input int pt, input int go);
    chk({nm, ".ball_x"}, int'(ball_x), x);
    chk({nm, ".ball_y"}, int'(ball_y), y);
    chk({nm, ".dir_x"}, int'(dir_x), dx);
    chk({nm, ".dir_y"}, int'(dir_y), dy);
    chk({nm, ".score_l"}, int'(score_l), sl);
    chk({nm, ".score_r"}, int'(score_r), sr);
    chk({nm, ".point"}, int'(point), pt);
    chk({nm, ".game_over"}, int'(game_over), go);
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_serve();
    @(negedge clk);
    serve = 1'b1;
    @(negedge clk);
    serve = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      mode    = tv[i].mode;
      en      = tv[i].en;
      en2     = tv[i].en2;
      pad_l_y = tv[i].pl;
      tick_n(tv[i].n);
      chk_all($sformatf("vec%0d", i), tv[i].x, tv[i].y,
              tv[i].dx, tv[i].dy, 0, 0, 0, 0);
    end
  endtask

  initial begin
    // demo bounce, top wall, then left paddle hit
    tv[0]  = mk(10, 0, 0, 0,   0, 326, 246, 1, 1);
    tv[1]  = mk(56, 3, 0, 0,   0, 550, 470, 1, 1);
    tv[2]  = mk( 1, 3, 0, 0,   0, 554, 472, 1, 0);
    tv[3]  = mk(19, 3, 0, 0,   0, 630, 396, 1, 0);
    tv[4]  = mk( 1, 3, 0, 0,   0, 632, 392, 0, 0);
    tv[5]  = mk(99, 3, 0, 0,   0, 236,   0, 0, 1);
    tv[6]  = mk(51, 3, 0, 0,   0,  32, 204, 0, 1);
    tv[7]  = mk( 1, 0, 0, 0,   0,  31, 205, 0, 1);
    tv[8]  = mk( 1, 3, 1, 0, 200,  27, 209, 0, 1);
    tv[9]  = mk( 1, 3, 1, 0, 200,  24, 213, 1, 1);
    // approach for a left miss, passing behind the paddle
    tv[10] = mk(80, 3, 0, 0,   0, 632, 392, 0, 0);
    tv[11] = mk(150, 3, 1, 0, 400, 32, 204, 0, 1);
    tv[12] = mk( 3, 3, 1, 0, 400,  20, 216, 0, 1);
    tv[13] = mk( 5, 3, 1, 0, 200,   0, 236, 0, 1);
    tv[14] = mk( 1, 3, 1, 0, 200,   0, 236, 0, 1);

    do_reset();
    chk_all("reset", 316, 236, 1, 1, 0, 0, 0, 0);
    tick();
    chk_all("idle_tick", 316, 236, 1, 1, 0, 0, 0, 0);

    // serve and tick in the same cycle: no move yet
    @(negedge clk);
    serve = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    serve = 1'b0;
    frame_tick = 1'b0;
    chk_all("serve_prio", 316, 236, 1, 1, 0, 0, 0, 0);
    run_vecs(0, 9);

    do_reset();
    do_serve();
    run_vecs(10, 13);
    tick();
    chk_all("left_miss", 316, 236, 0, 1, 0, 1, 1, 0);
    @(negedge clk);
    chk("miss_pulse_end", int'(point), 0);
    tick_n(60);
    chk_all("hold_done", 316, 236, 0, 1, 0, 1, 0, 0);
    tick();
    chk_all("resume", 312, 240, 0, 1, 0, 1, 0, 0);

    // right misses until the left player wins
    do_reset();
    en = 1'b0;
    en2 = 1'b1;
    pad_r_y = 10'd1000;
    mode = 2'd3;
    do_serve();
    for (int i = 0; i < 9; i++) begin
      tick_n(80);
      chk($sformatf("win%0d.score_l", i), int'(score_l), i + 1);
      chk($sformatf("win%0d.point", i), int'(point), 1);
      chk($sformatf("win%0d.ball_x", i), int'(ball_x), 316);
      chk($sformatf("win%0d.dir_x", i), int'(dir_x), 1);
      tick_n(60);
      chk($sformatf("win%0d.game_over", i), int'(game_over),
          (i == 8) ? 1 : 0);
    end
    tick_n(3);
    chk("over.score_l", int'(score_l), 9);
    chk("over.ball_x", int'(ball_x), 316);
    chk("over.game_over", int'(game_over), 1);
    do_serve();
    chk_all("over_serve", 316, 236, 1, 1, 0, 0, 0, 0);
    tick();
    chk_all("over_play", 320, 240, 1, 1, 0, 0, 0, 0);

    // asynchronous reset in the middle of play
    do_reset();
    en2 = 1'b0;
    do_serve();
    tick_n(5);
    chk_all("pre_rst", 336, 256, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_all("async_rst", 316, 236, 1, 1, 0, 0, 0, 0);
    serve = 1'b1;
    tick_n(3);
    serve = 1'b0;
    chk_all("in_rst", 316, 236, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    tick_n(3);
    chk_all("post_rst_idle", 316, 236, 1, 1, 0, 0, 0, 0);
    do_serve();
    tick();
    chk_all("post_rst_play", 320, 240, 1, 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
